// File: rtl/z80_bus_master_if.sv
// Request/response port and Z80 pin group shared by the bus master and its environment.
interface z80_bus_master_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_kind;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] A;
    logic [DW-1:0] D_out;
    logic          D_oe;
    logic [DW-1:0] D_in;
    logic          nMREQ;
    logic          nIORQ;
    logic          nRD;
    logic          nWR;
    logic          nWAIT;

    modport master (
        input  req_valid, req_kind, req_addr, req_wdata,
        input  D_in, nWAIT,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output A, D_out, D_oe, nMREQ, nIORQ, nRD, nWR
    );

    modport slave (
        output req_valid, req_kind, req_addr, req_wdata,
        output D_in, nWAIT,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  A, D_out, D_oe, nMREQ, nIORQ, nRD, nWR
    );
endinterface

// File: rtl/z80_bus_master.sv
// Z80-style T1/T2/TW/T3 bus cycle generator driven by a valid/ready request port.
module z80_bus_master #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int MEM_WAIT = 0,
    parameter int IO_WAIT  = 1,
    parameter int WAIT_MAX = 255
) (
    input logic              CPUCLK,
    input logic              nRESET,
    z80_bus_master_if.master bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] T1   = 3'd1;
    localparam logic [2:0] T2   = 3'd2;
    localparam logic [2:0] TW   = 3'd3;
    localparam logic [2:0] T3   = 3'd4;

    localparam logic [3:0] MW   = 4'(MEM_WAIT);
    localparam logic [3:0] IW   = 4'(IO_WAIT);
    localparam logic [7:0] WMAX = 8'(WAIT_MAX);

    logic [2:0]    state, state_n;
    logic [3:0]    auto_q, auto_n;
    logic [7:0]    ext_q, ext_n;
    logic [1:0]    kind_q, kind_n;
    logic [AW-1:0] addr_q, addr_n;
    logic [DW-1:0] wdata_q, wdata_n;
    logic          timeout;

    logic          rdy;
    logic          rsp_v;
    logic          rsp_e;
    logic [DW-1:0] rdata;
    logic [AW-1:0] a_q;
    logic [DW-1:0] dout;
    logic          oe;
    logic          nmreq;
    logic          niorq;
    logic          nrd;
    logic          nwr;

    logic          hs;
    logic          io;
    logic          wr;
    logic          act;
    logic          mid;

    assign hs = bus.req_valid && rdy;

    always_comb begin
        state_n = state;
        auto_n  = auto_q;
        ext_n   = ext_q;
        kind_n  = kind_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        timeout = 1'b0;
        unique case (state)
            IDLE: begin
                if (hs) begin
                    state_n = T1;
                    kind_n  = bus.req_kind;
                    addr_n  = bus.req_addr;
                    wdata_n = bus.req_wdata;
                end
            end
            T1: begin
                state_n = T2;
                auto_n  = kind_q[1] ? IW : MW;
                ext_n   = 8'd0;
            end
            T2: begin
                if (auto_q != 4'd0) begin
                    state_n = TW;
                    auto_n  = auto_q - 4'd1;
                end else if (!bus.nWAIT) begin
                    state_n = TW;
                end else begin
                    state_n = T3;
                end
            end
            TW: begin
                // Auto-waits run out before the external wait line is heeded.
                if (auto_q != 4'd0) begin
                    auto_n = auto_q - 4'd1;
                end else if (bus.nWAIT) begin
                    state_n = T3;
                end else if (ext_q + 8'd1 == WMAX) begin
                    state_n = T3;
                    timeout = 1'b1;
                end else begin
                    ext_n = ext_q + 8'd1;
                end
            end
            T3:      state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign io  = kind_n[1];
    assign wr  = kind_n[0];
    assign act = (state_n == T1) || (state_n == T2) || (state_n == TW);
    assign mid = (state_n == T2) || (state_n == TW);

    // Pin outputs are registered from the next state so they change cleanly on the edge.
    always_ff @(posedge CPUCLK or negedge nRESET) begin
        if (!nRESET) begin
            state   <= IDLE;
            auto_q  <= 4'd0;
            ext_q   <= 8'd0;
            kind_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdy     <= 1'b0;
            rsp_v   <= 1'b0;
            rsp_e   <= 1'b0;
            rdata   <= '0;
            a_q     <= '0;
            dout    <= '0;
            oe      <= 1'b0;
            nmreq   <= 1'b1;
            niorq   <= 1'b1;
            nrd     <= 1'b1;
            nwr     <= 1'b1;
        end else begin
            state   <= state_n;
            auto_q  <= auto_n;
            ext_q   <= ext_n;
            kind_q  <= kind_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            rdy     <= (state_n == IDLE);
            rsp_v   <= (state_n == T3);
            rsp_e   <= (state_n == T3) && timeout;
            nmreq   <= !(!io && act);
            niorq   <= !(io && mid);
            nrd     <= !(!wr && (io ? mid : act));
            nwr     <= !(wr && mid);
            oe      <= wr && (act || (state_n == T3));
            if (state_n == T1) begin
                a_q <= addr_n;
                if (wr) dout <= wdata_n;
            end
            if (state_n == T3)
                rdata <= (!kind_q[0] && !timeout) ? bus.D_in : '0;
        end
    end

    assign bus.req_ready = rdy;
    assign bus.rsp_valid = rsp_v;
    assign bus.rsp_err   = rsp_e;
    assign bus.rsp_rdata = rdata;
    assign bus.A         = a_q;
    assign bus.D_out     = dout;
    assign bus.D_oe      = oe;
    assign bus.nMREQ     = nmreq;
    assign bus.nIORQ     = niorq;
    assign bus.nRD       = nrd;
    assign bus.nWR       = nwr;
endmodule

// File: tb/tb_z80_bus_master.sv
// Directed bench for z80_bus_master: per-cycle strobe traces against hand-derived patterns.
module tb_z80_bus_master;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    z80_bus_master_if #(.AW(16), .DW(8)) bus ();

    z80_bus_master #(
        .AW(16), .DW(8), .MEM_WAIT(0), .IO_WAIT(1), .WAIT_MAX(4)
    ) dut (
        .CPUCLK(clk),
        .nRESET(rst_n),
        .bus(bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Per-cycle traces; bit k is cycle k after the handshake edge.
    logic [15:0] v_mreq, v_iorq, v_rd, v_wr, v_oe, v_rv, v_err, v_rdy;
    logic [7:0]  c_rdata [16];
    logic [7:0]  c_dout  [16];
    logic [15:0] c_a     [16];

    task automatic issue(input logic [1:0] kind, input logic [15:0] addr,
                         input logic [7:0] wdata);
        int n;
        bus.req_valid = 1'b1;
        bus.req_kind  = kind;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!bus.req_ready) begin
            errors++;
            $display("FAIL issue_ready got %b exp 1", bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic capture(input int n, input logic [15:0] wmask,
                           input logic [7:0] din);
        v_mreq = '1; v_iorq = '1; v_rd = '1; v_wr = '1;
        v_oe = '0; v_rv = '0; v_err = '0; v_rdy = '0;
        for (int k = 1; k <= n; k++) begin
            bus.nWAIT  = !wmask[k];
            bus.D_in   = wmask[k] ? 8'hEE : din;
            v_mreq[k]  = bus.nMREQ;
            v_iorq[k]  = bus.nIORQ;
            v_rd[k]    = bus.nRD;
            v_wr[k]    = bus.nWR;
            v_oe[k]    = bus.D_oe;
            v_rv[k]    = bus.rsp_valid;
            v_err[k]   = bus.rsp_err;
            v_rdy[k]   = bus.req_ready;
            c_rdata[k] = bus.rsp_rdata;
            c_dout[k]  = bus.D_out;
            c_a[k]     = bus.A;
            @(posedge clk); #1;
        end
        bus.nWAIT = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus.nMREQ, bus.nIORQ, bus.nRD, bus.nWR} !== 4'hF) begin
            errors++;
            $display("FAIL reset_strobes got %h exp f",
                     {bus.nMREQ, bus.nIORQ, bus.nRD, bus.nWR});
        end
        checks++;
        if ({bus.D_oe, bus.rsp_valid, bus.rsp_err, bus.req_ready} !== 4'h0) begin
            errors++;
            $display("FAIL reset_flags got %h exp 0",
                     {bus.D_oe, bus.rsp_valid, bus.rsp_err, bus.req_ready});
        end
        checks++;
        if ({bus.A, bus.D_out, bus.rsp_rdata} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0",
                     {bus.A, bus.D_out, bus.rsp_rdata});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b exp 1", bus.req_ready);
        end
    endtask

    task automatic test_mem_read;
        issue(2'b00, 16'h1234, 8'h00);
        capture(5, 16'h0000, 8'hA5);
        checks++;
        if (v_mreq !== 16'hFFF9 || v_rd !== 16'hFFF9) begin
            errors++;
            $display("FAIL mrd_strobe got %h/%h exp fff9/fff9", v_mreq, v_rd);
        end
        checks++;
        if (v_iorq !== 16'hFFFF || v_wr !== 16'hFFFF || v_oe !== 16'h0) begin
            errors++;
            $display("FAIL mrd_idle got %h/%h/%h exp ffff/ffff/0000",
                     v_iorq, v_wr, v_oe);
        end
        checks++;
        if (v_rv !== 16'h0008 || v_err !== 16'h0 || c_rdata[3] !== 8'hA5) begin
            errors++;
            $display("FAIL mrd_rsp got %h/%h/%h exp 0008/0000/a5",
                     v_rv, v_err, c_rdata[3]);
        end
        checks++;
        if (c_a[1] !== 16'h1234 || c_a[5] !== 16'h1234 || v_rdy !== 16'h0030) begin
            errors++;
            $display("FAIL mrd_addr got %h/%h/%h exp 1234/1234/0030",
                     c_a[1], c_a[5], v_rdy);
        end
    endtask

    task automatic test_mem_write;
        issue(2'b01, 16'h8000, 8'h3C);
        capture(5, 16'h0000, 8'h00);
        checks++;
        if (v_mreq !== 16'hFFF9 || v_wr !== 16'hFFFB || v_rd !== 16'hFFFF) begin
            errors++;
            $display("FAIL mwr_strobe got %h/%h/%h exp fff9/fffb/ffff",
                     v_mreq, v_wr, v_rd);
        end
        checks++;
        if (v_oe !== 16'h000E || c_dout[1] !== 8'h3C || c_dout[3] !== 8'h3C) begin
            errors++;
            $display("FAIL mwr_data got %h/%h/%h exp 000e/3c/3c",
                     v_oe, c_dout[1], c_dout[3]);
        end
        checks++;
        if (v_rv !== 16'h0008 || v_err !== 16'h0 || c_a[2] !== 16'h8000) begin
            errors++;
            $display("FAIL mwr_rsp got %h/%h/%h exp 0008/0000/8000",
                     v_rv, v_err, c_a[2]);
        end
    endtask

    task automatic test_io_read;
        issue(2'b10, 16'h00FE, 8'h00);
        capture(6, 16'h0000, 8'h7F);
        checks++;
        if (v_iorq !== 16'hFFF3 || v_rd !== 16'hFFF3 || v_mreq !== 16'hFFFF) begin
            errors++;
            $display("FAIL iord_strobe got %h/%h/%h exp fff3/fff3/ffff",
                     v_iorq, v_rd, v_mreq);
        end
        checks++;
        if (v_rv !== 16'h0010 || c_rdata[4] !== 8'h7F) begin
            errors++;
            $display("FAIL iord_rsp got %h/%h exp 0010/7f", v_rv, c_rdata[4]);
        end
    endtask

    task automatic test_ext_wait;
        issue(2'b00, 16'h4321, 8'h00);
        capture(8, 16'h001C, 8'h5A);
        checks++;
        if (v_mreq !== 16'hFFC1 || v_rd !== 16'hFFC1) begin
            errors++;
            $display("FAIL wait_strobe got %h/%h exp ffc1/ffc1", v_mreq, v_rd);
        end
        checks++;
        if (v_rv !== 16'h0040 || v_err !== 16'h0 || c_rdata[6] !== 8'h5A) begin
            errors++;
            $display("FAIL wait_rsp got %h/%h/%h exp 0040/0000/5a",
                     v_rv, v_err, c_rdata[6]);
        end
    endtask

    task automatic test_timeout;
        issue(2'b00, 16'h0BAD, 8'h00);
        capture(8, 16'hFFFE, 8'h77);
        checks++;
        if (v_mreq !== 16'hFF81 || v_rd !== 16'hFF81) begin
            errors++;
            $display("FAIL tmo_strobe got %h/%h exp ff81/ff81", v_mreq, v_rd);
        end
        checks++;
        if (v_rv !== 16'h0080 || v_err !== 16'h0080 || c_rdata[7] !== 8'h00) begin
            errors++;
            $display("FAIL tmo_rsp got %h/%h/%h exp 0080/0080/00",
                     v_rv, v_err, c_rdata[7]);
        end
        issue(2'b00, 16'h0055, 8'h00);
        capture(4, 16'h0000, 8'h99);
        checks++;
        if (v_rv !== 16'h0008 || v_err !== 16'h0 || c_rdata[3] !== 8'h99) begin
            errors++;
            $display("FAIL tmo_next got %h/%h/%h exp 0008/0000/99",
                     v_rv, v_err, c_rdata[3]);
        end
    endtask

    task automatic test_back_to_back;
        int first;
        int second;
        first  = -1;
        second = -1;
        bus.req_valid = 1'b1;
        bus.req_kind  = 2'b00;
        bus.req_addr  = 16'h2000;
        bus.D_in      = 8'h00;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        checks++;
        if (first < 0 || second - first != 4) begin
            errors++;
            $display("FAIL b2b_spacing got %0d exp 4", second - first);
        end
    endtask

    task automatic test_reset_mid;
        logic seen;
        issue(2'b11, 16'h0077, 8'hC3);
        bus.nWAIT = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({bus.nIORQ, bus.nWR, bus.D_oe} !== 3'b001) begin
            errors++;
            $display("FAIL rst_pre got %b exp 001",
                     {bus.nIORQ, bus.nWR, bus.D_oe});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.nMREQ, bus.nIORQ, bus.nRD, bus.nWR, bus.D_oe, bus.req_ready}
            !== 6'b111100) begin
            errors++;
            $display("FAIL rst_async got %b exp 111100",
                     {bus.nMREQ, bus.nIORQ, bus.nRD, bus.nWR, bus.D_oe,
                      bus.req_ready});
        end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            seen = seen | bus.rsp_valid;
        end
        bus.nWAIT = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            seen = seen | bus.rsp_valid;
        end
        checks++;
        if (seen !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_after got %b/%b exp 0/1", seen, bus.req_ready);
        end
        issue(2'b00, 16'h1357, 8'h00);
        capture(4, 16'h0000, 8'h24);
        checks++;
        if (v_rv !== 16'h0008 || c_rdata[3] !== 8'h24 || c_a[1] !== 16'h1357) begin
            errors++;
            $display("FAIL rst_read got %h/%h/%h exp 0008/24/1357",
                     v_rv, c_rdata[3], c_a[1]);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_kind  = 2'b00;
        bus.req_addr  = 16'h0;
        bus.req_wdata = 8'h0;
        bus.D_in      = 8'h0;
        bus.nWAIT     = 1'b1;
        test_reset;
        test_mem_read;
        test_mem_write;
        test_io_read;
        test_ext_wait;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/z80_bus_master.md
Name: z80_bus_master

Overview:
- Parametrised Z80-style bus cycle generator.
- Converts a simple valid/ready request port into memory and I/O read/write cycles with T1/T2/TW/T3 timing.
- Generalises the fixed 16-bit/8-bit CPU pin set to configurable address and data widths, with programmable automatic wait states and a nWAIT timeout.
- Sits between internal sequencing logic (or a test bench driver) and the external Z80 pin group.

Parameters:
- AW, 16, address bus width.
- DW, 8, data bus width.
- MEM_WAIT, 0, automatic wait states inserted after T2 for memory cycles (0-15).
- IO_WAIT, 1, automatic wait states inserted after T2 for I/O cycles (0-15).
- WAIT_MAX, 255, maximum TW cycles caused by external nWAIT before abort (1-255).

Ports:
- CPUCLK, in, 1, system clock; all state changes on the rising edge.
- nRESET, in, 1, asynchronous active-low reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, request accepted when req_valid && req_ready.
- req_kind, in, 2, 00 mem read, 01 mem write, 10 I/O read, 11 I/O write.
- req_addr, in, AW, access address.
- req_wdata, in, DW, write data.
- rsp_valid, out, 1, one-cycle completion pulse.
- rsp_err, out, 1, timeout flag; valid with rsp_valid.
- rsp_rdata, out, DW, read data; valid with rsp_valid for reads.
- A, out, AW, address bus.
- D_out, out, DW, data bus drive value.
- D_oe, out, 1, data bus output enable.
- D_in, in, DW, data bus sampled value.
- nMREQ, out, 1, memory request, active-low.
- nIORQ, out, 1, I/O request, active-low.
- nRD, out, 1, read strobe, active-low.
- nWR, out, 1, write strobe, active-low.
- nWAIT, in, 1, external wait, active-low.

Behaviour:
- Reset (nRESET=0) is asynchronous. It forces:
  - state IDLE; req_ready=0 while nRESET is low;
  - nMREQ=nIORQ=nRD=nWR=1, D_oe=0;
  - A=0, D_out=0, rsp_valid=0, rsp_err=0, rsp_rdata=0; wait counters=0.
- Reset mid-cycle: strobes release immediately, the request is dropped, and no rsp_valid is ever produced for it.
- States and transitions:
  - IDLE: req_ready=1. On handshake, latch kind/addr/wdata and go to T1.
  - T1 -> T2 unconditionally.
  - T2: if auto-wait count > 0, go to TW. Otherwise sample nWAIT: 0 -> TW, 1 -> T3.
  - TW: first exhaust the auto-wait count (nWAIT is ignored while auto-waits remain). Then nWAIT=1 -> T3. nWAIT=0 -> stay in TW and increment the external-wait count; on reaching WAIT_MAX, go to T3 with the abort flag set.
  - T3 -> IDLE unconditionally.
- Auto-wait count is loaded in T1 with MEM_WAIT or IO_WAIT according to req_kind[1].
- Outputs registered per state:
  - A = latched address from T1 through T3; A holds its last value in IDLE.
  - Memory read: nMREQ=0 and nRD=0 in T1, T2, TW.
  - Memory write: nMREQ=0 in T1, T2, TW; nWR=0 in T2 and TW only.
  - I/O read/write: nIORQ=0 and the matching strobe=0 in T2 and TW only.
  - All strobes are high in T3 and IDLE.
  - Writes: D_out = wdata and D_oe=1 from T1 through T3; D_oe=0 otherwise.
- Read data: D_in is sampled on the edge leaving T2/TW into T3 and presented on rsp_rdata.
- Completion: rsp_valid=1 for exactly the T3 cycle, for both reads and writes. rsp_err=1 only on a timeout abort; rsp_rdata is undefined-but-stable (zero) on error.
- Latency:
  - zero-wait access = 4 cycles handshake-to-handshake (T1, T2, T3, IDLE);
  - each TW adds 1 cycle;
  - there is no back-to-back acceptance in T3.
- nWAIT is ignored in IDLE, T1 and T3.
- Address width rule: no truncation or extension; A is exactly AW bits.

Test Plan:
- Mem read, addr 16'h1234, D_in=8'hA5, nWAIT=1, MEM_WAIT=0 -> nMREQ/nRD low for 2 cycles; rsp_valid in 3rd cycle after handshake with rsp_rdata=8'hA5, rsp_err=0.
- Mem write, addr 16'h8000, wdata 8'h3C -> D_oe high for 3 cycles with D_out=8'h3C; nWR low for exactly 1 cycle (T2); rsp_valid 1 cycle, rsp_err=0.
- I/O read with IO_WAIT=1, addr 16'h00FE, D_in=8'h7F -> nIORQ low in T2 and 1 TW; rsp_valid 4 cycles after handshake; rsp_rdata=8'h7F.
- Mem read with nWAIT held low 3 cycles after T2 -> exactly 3 TW cycles; rsp_valid 6 cycles after handshake; data sampled after nWAIT rises.
- WAIT_MAX=4 with nWAIT stuck low -> 4 TW cycles, then T3 with rsp_valid=1 and rsp_err=1; next request accepted normally.
- nRESET asserted during TW of an I/O write -> all strobes high and D_oe=0 in the same cycle without a clock edge; no rsp_valid; after release, req_ready=1 and a new read completes correctly.
